fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 33 +++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: PC hand-off, instruction memory read port, redirect/stall
// controls and the fetched-instruction outputs of the fetch sequencer.
interface fetch_if;
  logic [15:0] currentInst;
  logic [15:0] nextInst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        jump;
  logic [15:0] jump_target;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        fetch_err;

  modport master (
    input  currentInst, imem_ack, imem_rdata, jump, jump_target,
           branch_taken, branch_target, stall,
    output nextInst, imem_req, imem_addr, instr_valid, instr_out, pc_out,
           fetch_err
  );

  modport slave (
    output currentInst, imem_ack, imem_rdata, jump, jump_target,
           branch_taken, branch_target, stall,
    input  nextInst, imem_req, imem_addr, instr_valid, instr_out, pc_out,
           fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory read per PC, steers the
// external PC register via nextInst, handles stalls, redirects and ack timeout.
//
// state  | meaning
// S_IDLE | single settling cycle after reset release, no request
// S_REQ  | read request outstanding at currentInst
// S_HOLD | fetched word parked while downstream stalls
// S_ERR  | ack timeout seen; frozen until reset
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          ACK_TIMEOUT = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.master bus
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;

  state_t          state_q;
  logic            req_q;
  logic            valid_q;
  logic            err_q;
  logic [15:0]     instr_q;
  logic [15:0]     pc_q;
  logic [CW-1:0]   wait_q;

  logic            redirect;
  logic [15:0]     target;
  logic            ack_take;
  logic [15:0]     next_d;

  always_comb begin
    redirect = (bus.jump || bus.branch_taken) && (state_q != S_ERR);
    target   = (bus.jump ? bus.jump_target : bus.branch_target) & 16'hFFFE;
    ack_take = (state_q == S_REQ) && bus.imem_ack && !redirect;
    // Reset term keeps the PC register loading RESET_PC while rst_n is low.
    if (!rst_n)        next_d = RESET_PC;
    else if (redirect) next_d = target;
    else if (ack_take) next_d = bus.currentInst + 16'd2;
    else               next_d = bus.currentInst;
  end

  assign bus.nextInst    = next_d;
  assign bus.imem_addr   = bus.currentInst;
  assign bus.imem_req    = req_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_q;
  assign bus.fetch_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      wait_q  <= '0;
    end else if (state_q != S_ERR) begin
      if (redirect) begin
        state_q <= S_REQ;
        req_q   <= 1'b1;
        valid_q <= 1'b0;
        wait_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
          S_REQ: begin
            if (bus.imem_ack) begin
              instr_q <= bus.imem_rdata;
              pc_q    <= bus.currentInst;
              valid_q <= 1'b1;
              wait_q  <= '0;
              if (bus.stall) begin
                state_q <= S_HOLD;
                req_q   <= 1'b0;
              end
            end else begin
              wait_q  <= wait_q + 1'b1;
              valid_q <= 1'b0;
              if (wait_q == CW'(ACK_TIMEOUT - 1)) begin
                state_q <= S_ERR;
                req_q   <= 1'b0;
                err_q   <= 1'b1;
              end
            end
          end
          // valid stays up into the first S_REQ cycle after the stall lifts
          S_HOLD: begin
            if (!bus.stall) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= S_ERR;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_sequencer;
  localparam logic [15:0] RPC = 16'h0100;
  localparam int          TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  int          tests = 0;
  int          failed = 0;

  fetch_if bus();

  fetch_sequencer #(.RESET_PC(RPC), .ACK_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // PC register outside the block
  always @(posedge clk) pc <= bus.nextInst;
  assign bus.currentInst = pc;

  function automatic logic [15:0] memfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction
  assign bus.imem_rdata = memfn(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch unit must look like this cycle
  bit          m_idle, m_hold, m_err, m_valid;
  int          m_wait;
  logic [15:0] m_instr, m_pc;

  always @(negedge clk) begin : model_cmp
    logic        redir;
    logic        fetching;
    logic [15:0] tgt;
    logic [15:0] exp_next;
    if (!rst_n) begin
      chk("rst_next", bus.nextInst, RPC);
      chk("rst_req", bus.imem_req, 0);
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_instr", bus.instr_out, 0);
      chk("rst_pc", bus.pc_out, 0);
      chk("rst_err", bus.fetch_err, 0);
      m_idle = 1; m_hold = 0; m_err = 0; m_valid = 0; m_wait = 0;
      m_instr = 0; m_pc = 0;
    end else begin
      redir    = !m_err && (bus.jump || bus.branch_taken);
      tgt      = (bus.jump ? bus.jump_target : bus.branch_target) & 16'hFFFE;
      fetching = !m_idle && !m_err && !m_hold;
      exp_next = redir ? tgt : (fetching && bus.imem_ack) ? pc + 16'd2 : pc;
      chk("m_next", bus.nextInst, exp_next);
      chk("m_req", bus.imem_req, fetching);
      if (fetching) chk("m_addr", bus.imem_addr, pc);
      chk("m_valid", bus.instr_valid, m_valid);
      chk("m_instr", bus.instr_out, m_instr);
      chk("m_pcout", bus.pc_out, m_pc);
      chk("m_err", bus.fetch_err, m_err);
      if (m_err) begin
      end else if (redir) begin
        m_idle = 0; m_hold = 0; m_valid = 0; m_wait = 0;
      end else if (m_idle) begin
        m_idle = 0;
      end else if (m_hold) begin
        if (!bus.stall) m_hold = 0;
      end else if (bus.imem_ack) begin
        m_instr = memfn(pc); m_pc = pc; m_valid = 1; m_wait = 0;
        m_hold = bus.stall;
      end else begin
        m_wait++;
        m_valid = 0;
        if (m_wait == TMO) m_err = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.imem_ack = 0; bus.jump = 0; bus.jump_target = 0;
    bus.branch_taken = 0; bus.branch_target = 0; bus.stall = 0;
  endtask

  initial begin
    quiet();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_next", bus.nextInst, 16'h0100);
    chk("reset_req", bus.imem_req, 0);
    chk("reset_valid", bus.instr_valid, 0);
    rst_n = 1;

    // back-to-back acks from the reset PC; an ack during S_IDLE is ignored
    bus.imem_ack = 1;
    tick();
    chk("idle_ack_ignored", bus.instr_valid, 0);
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_pc", bus.pc_out, RPC + 16'(2 * i));
      chk("seq_instr", bus.instr_out, memfn(RPC + 16'(2 * i)));
      chk("seq_valid", bus.instr_valid, 1);
    end

    // redirect to 0, then pc_out 0,2,4,6
    bus.jump = 1; bus.jump_target = 16'h0000;
    tick();
    bus.jump = 0;
    chk("j0_valid", bus.instr_valid, 0);
    chk("j0_addr", bus.imem_addr, 16'h0000);
    chk("j0_pcout_held", bus.pc_out, 16'h0106);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq0_pc", bus.pc_out, 16'(2 * i));
    end

    // wrap at 0xFFFE
    bus.imem_ack = 0; bus.jump = 1; bus.jump_target = 16'hFFFE;
    tick();
    bus.jump = 0; bus.imem_ack = 1;
    #1;
    chk("wrap_next", bus.nextInst, 16'h0000);
    tick();
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    chk("wrap_pcout", bus.pc_out, 16'hFFFE);

    // jump beats branch, odd target aligned, ack discarded
    bus.jump = 1; bus.jump_target = 16'h0041;
    bus.branch_taken = 1; bus.branch_target = 16'h0100;
    #1;
    chk("prio_next", bus.nextInst, 16'h0040);
    tick();
    quiet();
    chk("prio_addr", bus.imem_addr, 16'h0040);
    chk("prio_valid", bus.instr_valid, 0);
    chk("prio_pcout", bus.pc_out, 16'hFFFE);

    // stall for 3 cycles across an ack at 0x0010
    bus.jump = 1; bus.jump_target = 16'h0010;
    tick();
    bus.jump = 0; bus.imem_ack = 1; bus.stall = 1;
    tick();
    bus.imem_ack = 0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_pcout", bus.pc_out, 16'h0010);
      chk("hold_req", bus.imem_req, 0);
      chk("hold_pc", pc, 16'h0012);
      if (k == 2) bus.stall = 0;
      tick();
    end
    chk("resume_valid", bus.instr_valid, 1);
    chk("resume_req", bus.imem_req, 1);
    chk("resume_addr", bus.imem_addr, 16'h0012);
    tick();
    chk("after_valid", bus.instr_valid, 0);

    // ack timeout
    bus.jump = 1; bus.jump_target = 16'h0200;
    tick();
    bus.jump = 0;
    repeat (TMO - 1) tick();
    chk("tmo_pre_req", bus.imem_req, 1);
    chk("tmo_pre_err", bus.fetch_err, 0);
    tick();
    chk("tmo_err", bus.fetch_err, 1);
    chk("tmo_req", bus.imem_req, 0);
    chk("tmo_valid", bus.instr_valid, 0);
    bus.jump = 1; bus.jump_target = 16'h0300; bus.imem_ack = 1;
    repeat (3) tick();
    chk("err_sticky", bus.fetch_err, 1);
    chk("err_noredirect", bus.imem_req, 0);
    quiet();

    // async reset mid-wait
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
    repeat (3) tick();
    chk("wait_req", bus.imem_req, 1);
    #2;
    rst_n = 0;
    #1;
    chk("async_req", bus.imem_req, 0);
    chk("async_next", bus.nextInst, 16'h0100);
    chk("async_err", bus.fetch_err, 0);
    bus.imem_ack = 1;
    tick(); tick();
    rst_n = 1;
    chk("post_idle_req", bus.imem_req, 0);
    tick();
    chk("post_valid", bus.instr_valid, 0);
    chk("post_req", bus.imem_req, 1);
    chk("post_addr", bus.imem_addr, 16'h0100);
    quiet();

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      if (n % 300 == 150) begin
        quiet();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
      end
      bus.imem_ack      = ($urandom_range(0, 9) < 6);
      bus.stall         = ($urandom_range(0, 9) < 3);
      bus.jump          = ($urandom_range(0, 19) == 0);
      bus.branch_taken  = ($urandom_range(0, 19) == 0);
      bus.jump_target   = 16'($urandom);
      bus.branch_target = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
